// File: rtl/sound_cmd_mailbox_if.sv
// Signal bundle between the 68010 side, the 6502 side and the sound command mailbox.
// The master modport is the environment (both CPUs). The slave modport is the mailbox.
interface sound_cmd_mailbox_if;
  logic       main_wr_b;
  logic       main_rd_b;
  logic [7:0] main_din;
  logic [7:0] main_dout;
  logic       main_irq_b;
  logic       snd_wr_b;
  logic       snd_rd_b;
  logic       snd_stat_rd_b;
  logic [7:0] snd_din;
  logic [7:0] snd_dout;
  logic       snd_dout_en;
  logic       snd_nmi_b;
  logic       cmd_full;
  logic       resp_full;

  modport master (
    output main_wr_b, main_rd_b, main_din, snd_wr_b, snd_rd_b, snd_stat_rd_b, snd_din,
    input  main_dout, main_irq_b, snd_dout, snd_dout_en, snd_nmi_b, cmd_full, resp_full
  );

  modport slave (
    input  main_wr_b, main_rd_b, main_din, snd_wr_b, snd_rd_b, snd_stat_rd_b, snd_din,
    output main_dout, main_irq_b, snd_dout, snd_dout_en, snd_nmi_b, cmd_full, resp_full
  );
endinterface

// File: rtl/sound_cmd_mailbox.sv
// Bidirectional byte mailbox between the 68010 main CPU and the I/O-sound 6502.
// Defining SND_CMD_FIFO_EN replaces the single command latch with a FIFO_DEPTH-entry FIFO.
module sound_cmd_mailbox #(
  parameter int unsigned NMI_PULSE  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  sound_cmd_mailbox_if.slave bus
);

  if (NMI_PULSE < 1 || NMI_PULSE > 15) begin : g_bad_nmi_pulse
    $error("NMI_PULSE must be in 1..15");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 in 2..16");
  end

  // Strobe order: main_wr, main_rd, snd_wr, snd_rd, snd_stat_rd
  logic [4:0] strb_now, strb_q, strb_fall;
  logic       armed_q;
  logic       cmd_wr, resp_rd, resp_wr, cmd_rd, stat_rd;

  assign strb_now = {bus.main_wr_b, bus.main_rd_b, bus.snd_wr_b, bus.snd_rd_b, bus.snd_stat_rd_b};
  // A strobe held low across reset release would otherwise look like a fresh access.
  assign strb_fall = armed_q ? (strb_q & ~strb_now) : 5'b00000;
  assign {cmd_wr, resp_rd, resp_wr, cmd_rd, stat_rd} = strb_fall;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      strb_q  <= '1;
      armed_q <= 1'b0;
    end else begin
      strb_q  <= strb_now;
      armed_q <= 1'b1;
    end
  end

  logic [7:0] resp_latch_q;
  logic       resp_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_latch_q <= 8'h00;
      resp_full_q  <= 1'b0;
    end else if (resp_wr) begin
      resp_latch_q <= bus.snd_din;
      resp_full_q  <= 1'b1;
    end else if (resp_rd) begin
      resp_full_q  <= 1'b0;
    end
  end

  logic [7:0] cmd_head;
  logic       cmd_avail;
  logic       cmd_fifo_full;
  logic       cmd_push;
  logic       cmd_ovr;

`ifdef SND_CMD_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        cmd_pop;

  assign cmd_avail     = (wr_ptr_q != rd_ptr_q);
  assign cmd_fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_pop       = cmd_rd && cmd_avail;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign cmd_push      = cmd_wr && (!cmd_fifo_full || cmd_pop);
  assign cmd_ovr       = cmd_wr && !cmd_push;
  assign cmd_head      = cmd_avail ? fifo_mem[rd_ptr_q[AW-1:0]] : 8'h00;
  assign wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, cmd_push};
  assign rd_ptr_d      = rd_ptr_q + {{AW{1'b0}}, cmd_pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (cmd_push) fifo_mem[wr_ptr_q[AW-1:0]] <= bus.main_din;
  end
`else
  logic [7:0] cmd_latch_q, cmd_latch_d;
  logic       cmd_full_q, cmd_full_d;

  assign cmd_push      = cmd_wr;
  assign cmd_ovr       = cmd_wr && cmd_full_q && !cmd_rd;
  assign cmd_avail     = cmd_full_q;
  assign cmd_fifo_full = 1'b0;
  assign cmd_head      = cmd_latch_q;

  always_comb begin
    // NOTE: defaults first so no path leaves a next-state undriven (no latches).
    cmd_latch_d = cmd_latch_q;
    cmd_full_d  = cmd_full_q;
    if (cmd_wr) begin
      cmd_latch_d = bus.main_din;
      cmd_full_d  = 1'b1;
    end else if (cmd_rd) begin
      cmd_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_latch_q <= 8'h00;
      cmd_full_q  <= 1'b0;
    end else begin
      cmd_latch_q <= cmd_latch_d;
      cmd_full_q  <= cmd_full_d;
    end
  end
`endif

  logic       ovr_q, ovr_d;
  logic [3:0] nmi_cnt_q, nmi_cnt_d;
  logic       nmi_b_q;

  always_comb begin
    ovr_d = ovr_q;
    if (stat_rd) ovr_d = 1'b0;
    if (cmd_ovr) ovr_d = 1'b1;
    // Every accepted command reloads the counter, stretching an active pulse.
    nmi_cnt_d = nmi_cnt_q;
    if (cmd_push)                nmi_cnt_d = 4'(NMI_PULSE);
    else if (nmi_cnt_q != 4'd0)  nmi_cnt_d = nmi_cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q     <= 1'b0;
      nmi_cnt_q <= 4'd0;
      nmi_b_q   <= 1'b1;
    end else begin
      ovr_q     <= ovr_d;
      nmi_cnt_q <= nmi_cnt_d;
      nmi_b_q   <= (nmi_cnt_d == 4'd0);
    end
  end

  logic [7:0] status;
  assign status = {cmd_avail, resp_full_q, ovr_q, cmd_fifo_full, 4'b0000};

  always_comb begin
    bus.snd_dout = 8'h00;
    if (!bus.snd_stat_rd_b)  bus.snd_dout = status;
    else if (!bus.snd_rd_b)  bus.snd_dout = cmd_head;
  end

  assign bus.snd_dout_en = ~bus.snd_rd_b | ~bus.snd_stat_rd_b;
  assign bus.snd_nmi_b   = nmi_b_q;
  assign bus.main_dout   = resp_latch_q;
  assign bus.main_irq_b  = ~resp_full_q;
  assign bus.cmd_full    = cmd_avail;
  assign bus.resp_full   = resp_full_q;

endmodule

// File: doc/sound_cmd_mailbox.md
Name: sound_cmd_mailbox

Overview:
- Bidirectional byte mailbox between the 68010 main CPU and the I/O-sound 6502.
- Sits directly upstream of the sound microprocessor:
  - drives its SNDNMI_b when a command arrives;
  - serves the 6502's RD68k_b/WR68k_b strobes decoded by its LS138.
- Holds one command byte (main->sound) and one response byte (sound->main) with full flags, overrun detection and a main-side response interrupt.

Parameters:
- NMI_PULSE, 4: clk cycles snd_nmi_b is held low per accepted command (1..15).
- FIFO_DEPTH, 4: command FIFO entries; power of 2, 2..16. Used only with SND_CMD_FIFO_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- main_wr_b  in  1  68k command write strobe, active low.
- main_rd_b  in  1  68k response read strobe, active low.
- main_din  in  8  68k write data.
- main_dout  out  8  response latch contents.
- main_irq_b  out  1  low while resp_full.
- snd_wr_b  in  1  6502 response write strobe (WR68k_b), active low.
- snd_rd_b  in  1  6502 command read strobe (RD68k_b), active low.
- snd_stat_rd_b  in  1  6502 status read strobe, active low.
- snd_din  in  8  6502 write data (SDout).
- snd_dout  out  8  data onto SDin.
- snd_dout_en  out  1  tristate enable for snd_dout.
- snd_nmi_b  out  1  to SNDNMI_b, active low.
- cmd_full  out  1  command pending.
- resp_full  out  1  response pending.

Behaviour:
- Strobe sampling:
  - Each strobe is registered once.
  - An access is the cycle where the registered value is 1 and the current value is 0 (falling edge).
  - Holding a strobe low counts as one access.
- Reset values:
  - cmd_latch=0, resp_latch=0, cmd_full=0, resp_full=0, overrun=0.
  - snd_nmi_b=1, main_irq_b=1, NMI counter=0.
  - Strobe history registers=1, so no false edge after reset.
- Command write (main_wr_b edge):
  - cmd_latch<=main_din and cmd_full<=1 on the next edge.
  - If cmd_full was already 1 and no same-cycle sound read: overwrite data, set overrun<=1.
  - NMI counter loads NMI_PULSE.
- NMI generator:
  - snd_nmi_b=0 while counter!=0; counter decrements each cycle.
  - A new command during an active pulse reloads the counter, so the pulse extends; there is no separate second edge.
- Command read (snd_rd_b edge): cmd_full<=0.
- snd_dout mux (combinational):
  - cmd_latch while snd_rd_b=0.
  - Status while snd_stat_rd_b=0: {cmd_full, resp_full, overrun, 5'b0}.
  - snd_dout_en = ~snd_rd_b | ~snd_stat_rd_b; snd_dout = 0 when not enabled.
  - If both strobes are low, the status byte takes priority.
- Status read edge: overrun<=0 (read-to-clear; the value shown is pre-clear).
- Simultaneous command write and command read edge:
  - Read returns the old byte.
  - New byte is stored; cmd_full stays 1; no overrun; NMI retriggers.
- Response write (snd_wr_b edge): resp_latch<=snd_din, resp_full<=1. Overwrite when full is allowed, with no flag.
- Response read (main_rd_b edge): resp_full<=0. main_dout = resp_latch continuously.
- Simultaneous response write and read edge: resp_full stays 1, latch updates.
- main_irq_b = ~resp_full (registered source, no glitch).
- Reset asserted mid-pulse: snd_nmi_b goes to 1 on the next edge; all flags clear.
- Latency:
  - Strobe edge to flag/latch update is 1 cycle after the strobe is registered.
  - snd_nmi_b falls on the cycle after the edge-detect cycle.

Optional Feature:
- Macro SND_CMD_FIFO_EN.
- When defined:
  - cmd_latch is replaced by a FIFO_DEPTH-entry FIFO with log2(FIFO_DEPTH)+1-bit wrapping read/write pointers.
  - cmd_full means "not empty".
  - Writes when full drop the byte and set overrun.
  - snd_rd_b edge pops; snd_dout shows the head entry.
  - Simultaneous push+pop when full: pop then push, accepted with no overrun.
  - Simultaneous push+pop when empty: push only; the read returns 0.
  - Status bit4 = FIFO full.
  - NMI retriggers on every accepted push.
- When undefined: single latch as above; status bit4 = 0.

Test Plan:
- Reset then idle 10 cycles -> snd_nmi_b=1, main_irq_b=1, cmd_full=0, status read = 8'h00.
- main_wr_b pulse with main_din=8'hA5 -> cmd_full=1; snd_nmi_b low exactly 4 cycles; snd_rd_b read returns 8'hA5; cmd_full=0.
- Two command writes 8'h11, 8'h22 with no read -> status=8'hA0; read returns 8'h22; next status read = 8'h80 or 8'h00 per full flag, overrun=0. With SND_CMD_FIFO_EN: reads return 8'h11 then 8'h22, no overrun.
- snd_wr_b with snd_din=8'h5C -> main_irq_b=0, main_dout=8'h5C; main_rd_b pulse -> main_irq_b=1.
- Command write and snd_rd_b edge in the same cycle, old=8'h01, new=8'h02 -> read sees 8'h01; cmd_full=1; next read 8'h02; overrun=0.
- Reset asserted 2 cycles into an NMI pulse -> snd_nmi_b=1 on the next edge; cmd_full=0; strobe held low through reset release causes no access.
